// File: rtl/n_post_norm.sv
// n_post_norm: FP add/sub back end -- normalise, round-to-nearest-even, pack IEEE-754 single
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   S_I, E_I, M_S, eq     sign, common exponent, raw mantissa {carry,hidden,frac,G,R,S}, exact cancel
//   out_valid / out_ready output handshake
//   R_O, of, uf, nx       packed result, overflow, underflow, inexact
module n_post_norm #(
  parameter int EW = 8,
  parameter int MW = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          S_I,
  input  logic [EW-1:0] E_I,
  input  logic [MW-1:0] M_S,
  input  logic          eq,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   R_O,
  output logic          of,
  output logic          uf,
  output logic          nx
);
  logic               w_adv;
  logic [4:0]         w_lz;
  logic               r_v1, r_s1, r_eq1, r_z1;
  logic signed [EW+1:0] r_e1;
  logic [MW-1:0]      r_m1;
  logic [4:0]         r_lz1;
  logic signed [EW+1:0] w_e2;
  logic [25:0]        w_m2;
  logic               w_uf2;
  logic               r_v2, r_s2, r_eq2, r_z2, r_uf2;
  logic signed [EW+1:0] r_e2;
  logic [25:0]        r_m2;
  logic               w_up, w_of, w_nxg;
  logic [22:0]        w_frac;
  logic signed [EW+1:0] w_e3;
  logic [31:0]        w_ro;
  assign w_adv    = !out_valid | out_ready;
  assign in_ready = w_adv;
  // Leading zeros of M_S[26:0]; the highest set bit wins, all-zero gives 27.
  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++)
      if (M_S[i]) w_lz = 5'(26 - i);
  end
  // Shift stage. The hidden bit is always 1 once normalised, so only
  // the 23 fraction bits plus G/R/S ([25:0]) travel on.
  assign w_e2  = r_m1[MW-1] ? r_e1 + 10'sd1 : r_e1 - $signed({5'd0, r_lz1});
  assign w_m2  = r_m1[MW-1] ? {r_m1[26:2], r_m1[1] | r_m1[0]} : r_m1[25:0] << r_lz1;
  assign w_uf2 = (w_e2 <= 10'sd0) & !r_eq1 & !r_z1;
  // Round stage: a fraction of all ones that rounds up wraps to zero, which
  // is exactly the 1.0 mantissa with the exponent bumped.
  assign w_up   = r_m2[2] & (r_m2[1] | r_m2[0] | r_m2[3]);
  assign w_frac = r_m2[25:3] + 23'(w_up);
  assign w_e3   = (w_up & (&r_m2[25:3])) ? r_e2 + 10'sd1 : r_e2;
  assign w_of   = w_e3 >= 10'sd255;
  assign w_nxg  = |r_m2[2:0];
  assign w_ro   = r_eq2 ? 32'h0 :
                  (r_z2 | r_uf2) ? {r_s2, 31'h0} :
                  w_of ? {r_s2, 8'hFF, 23'h0} :
                  {r_s2, w_e3[7:0], w_frac};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_s1      <= 1'b0;
      r_e1      <= '0;
      r_m1      <= '0;
      r_lz1     <= '0;
      r_eq1     <= 1'b0;
      r_z1      <= 1'b0;
      r_v2      <= 1'b0;
      r_s2      <= 1'b0;
      r_e2      <= '0;
      r_m2      <= '0;
      r_eq2     <= 1'b0;
      r_z2      <= 1'b0;
      r_uf2     <= 1'b0;
      out_valid <= 1'b0;
      R_O       <= '0;
      of        <= 1'b0;
      uf        <= 1'b0;
      nx        <= 1'b0;
    end else if (w_adv) begin
      r_v1      <= in_valid;
      r_s1      <= S_I;
      r_e1      <= {2'b0, E_I};
      r_m1      <= M_S;
      r_lz1     <= w_lz;
      r_eq1     <= eq;
      r_z1      <= (M_S == '0) | (E_I == '0);
      r_v2      <= r_v1;
      r_s2      <= r_s1;
      r_e2      <= w_e2;
      r_m2      <= w_m2;
      r_eq2     <= r_eq1;
      r_z2      <= r_z1;
      r_uf2     <= w_uf2;
      out_valid <= r_v2;
      R_O       <= w_ro;
      of        <= !r_eq2 & !r_z2 & !r_uf2 & w_of;
      uf        <= !r_eq2 & !r_z2 & r_uf2;
      nx        <= !r_eq2 & !r_z2 & (r_uf2 | w_of | w_nxg);
    end
  end
endmodule

// File: tb/tb_n_post_norm.sv
// tb_n_post_norm: scoreboard bench for n_post_norm with a value-level reference model
module tb_n_post_norm;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, S_I = 1'b0, eq = 1'b0, out_ready = 1'b1;
  logic [7:0]  E_I = '0;
  logic [27:0] M_S = '0;
  logic        in_ready, out_valid, of, uf, nx;
  logic [31:0] R_O;
  int          checks = 0, errors = 0, mode = 0;
  logic [34:0] sb[$];
  logic [34:0] mon_exp, held;
  bit          held_v = 1'b0;

  n_post_norm dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .S_I(S_I), .E_I(E_I), .M_S(M_S), .eq(eq),
    .out_valid(out_valid), .out_ready(out_ready),
    .R_O(R_O), .of(of), .uf(uf), .nx(nx)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [34:0] got, logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: value-level normalise / round-half-even on plain integers.
  function automatic logic [34:0] model(bit s, int e_i, int m, bit q);
    int e, mm, mant, rem;
    if (q) return 35'h0;
    if (m == 0 || e_i == 0) return {s, 31'h0, 3'b000};
    e  = e_i;
    mm = m;
    if (mm >= (1 << 27)) begin
      mm = (mm >> 1) | (mm & 1);
      e++;
    end else begin
      while (mm < (1 << 26)) begin
        mm = mm << 1;
        e--;
      end
    end
    if (e <= 0) return {s, 31'h0, 3'b011};
    mant = mm >> 3;
    rem  = mm & 7;
    if (rem > 4 || (rem == 4 && (mant & 1) == 1)) mant++;
    if (mant == (1 << 24)) begin
      mant = 1 << 23;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
    return {s, e[7:0], mant[22:0], 2'b00, rem != 0};
  endfunction

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (held_v && out_valid) chk("hold_stable", {R_O, of, uf, nx}, held);
    held_v = rst_n && out_valid && !out_ready;
    held   = {R_O, of, uf, nx};
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%h exp=none", R_O);
      end else begin
        mon_exp = sb.pop_front();
        chk("result", {R_O, of, uf, nx}, mon_exp);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(bit s, logic [7:0] e, logic [27:0] m, bit q);
    int n = 0;
    S_I = s; E_I = e; M_S = m; eq = q; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=in_ready0 exp=in_ready1");
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(s, int'(e), int'(m), q));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic direct(string name, bit s, logic [7:0] e, logic [27:0] m, bit q, logic [34:0] exp);
    issue(s, e, m, q);
    repeat (2) @(posedge clk);
    #1;
    chk(name, {R_O, of, uf, nx}, exp);
  endtask

  task automatic rand_op();
    bit          s = 1'($urandom);
    logic [7:0]  e = 8'($urandom_range(0, 255));
    logic [27:0] m = 28'($urandom) >> $urandom_range(0, 27);
    bit          q = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(250, 255));
    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(0, 28));
    issue(s, e, m, q);
  endtask

  initial begin
    int n;
    #2;
    chk("reset_outputs", {R_O, of, uf, nx}, 35'h0);
    chk("reset_handshake", {33'h0, out_valid, in_ready}, 35'h1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 8'd127, 28'h8000000, 1'b0);
    chk("lat_edge1", {34'h0, out_valid}, 35'h0);
    @(posedge clk);
    #1 chk("lat_edge2", {34'h0, out_valid}, 35'h0);
    @(posedge clk);
    #1 chk("lat_edge3", {34'h0, out_valid}, 35'h1);
    chk("t1_carry", {R_O, of, uf, nx}, {32'h4000_0000, 3'b000});
    direct("t2_deep_cancel", 1'b0, 8'd127, 28'h0000008, 1'b0, {32'h3400_0000, 3'b000});
    direct("t3_tie_odd", 1'b0, 8'd127, 28'h7FFFFFC, 1'b0, {32'h4000_0000, 3'b001});
    direct("t4_overflow", 1'b1, 8'd254, 28'h8000000, 1'b0, {32'hFF80_0000, 3'b101});
    direct("t5_eq", 1'b1, 8'd200, 28'h5A5A5A5, 1'b1, 35'h0);
    direct("t5_underflow", 1'b0, 8'd3, 28'h0000008, 1'b0, {32'h0, 3'b011});
    direct("zero_mant", 1'b1, 8'd100, 28'h0, 1'b0, {32'h8000_0000, 3'b000});
    direct("denorm_exp", 1'b1, 8'd0, 28'h4000000, 1'b0, {32'h8000_0000, 3'b000});
    direct("max_normal", 1'b0, 8'd254, 28'h7FFFFF8, 1'b0, {32'h7F7F_FFFF, 3'b000});
    direct("exp_to_zero", 1'b0, 8'd1, 28'h2000000, 1'b0, {32'h0, 3'b011});
    direct("round_overflow", 1'b0, 8'd254, 28'h7FFFFFC, 1'b0, {32'h7F80_0000, 3'b101});
    direct("tie_even", 1'b0, 8'd127, 28'h4000004, 1'b0, {32'h3F80_0000, 3'b001});
    direct("carry_sticky", 1'b0, 8'd127, 28'h8000003, 1'b0, {32'h4000_0000, 3'b001});
    mode = 2;
    out_ready = 1'b0;
    fork
      repeat (6) rand_op();
      begin
        repeat (8) @(negedge clk);
        chk("bp_in_ready", {34'h0, in_ready}, 35'h0);
        chk("bp_out_valid", {34'h0, out_valid}, 35'h1);
        mode = 0;
      end
    join
    mode = 1;
    repeat (300) begin
      rand_op();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    mode = 0;
    repeat (4) issue(1'b0, 8'd127, 28'h4000000, 1'b0);
    rst_n = 1'b0;
    #1 chk("rst_drops_valid", {34'h0, out_valid}, 35'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", {34'h0, out_valid}, 35'h0);
    end
    @(posedge clk);
    #1;
    direct("after_reset", 1'b1, 8'd130, 28'h6000000, 1'b0, {32'hC140_0000, 3'b000});
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
